// File: rtl/vga_sync_recovery.sv
// Recovers VGA timing from a raw hsync/vsync/rgb stream of unknown sync polarity
// and regenerates display enable plus active-area pixel coordinates.
module vga_sync_recovery #(
    parameter int H_ACTIVE    = 640,
    parameter int H_SYNC      = 96,
    parameter int H_BP        = 48,
    parameter int H_TOTAL     = 800,
    parameter int V_ACTIVE    = 480,
    parameter int V_SYNC      = 2,
    parameter int V_BP        = 33,
    parameter int V_TOTAL     = 525,
    parameter int LOCK_FRAMES = 2
) (
    input  logic       clk_pixel,
    input  logic       reset,
    input  logic       hsync,
    input  logic       vsync,
    input  logic [2:0] rgb,
    output logic [2:0] rgb_o,
    output logic       hsync_o,
    output logic       vsync_o,
    output logic       de,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       locked,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        POL     = 2'd0,
        SEARCH  = 2'd1,
        MEASURE = 2'd2,
        LOCKED  = 2'd3
    } state_t;

    localparam int         WINDOW    = H_TOTAL * V_TOTAL;
    localparam logic [18:0] WIN_LAST = 19'(WINDOW - 1);
    localparam logic [18:0] WIN_HALF = 19'(WINDOW / 2);
    localparam logic [9:0] H_LAST    = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST    = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_START   = 10'(H_SYNC + H_BP);
    localparam logic [9:0] H_END     = 10'(H_SYNC + H_BP + H_ACTIVE);
    localparam logic [9:0] V_START   = 10'(V_SYNC + V_BP);
    localparam logic [9:0] V_END     = 10'(V_SYNC + V_BP + V_ACTIVE);
    localparam logic [7:0] GOOD_LAST = 8'(LOCK_FRAMES - 1);

    state_t      r_state, w_nextState;
    logic [2:0]  r_rgb1, r_rgbO;
    logic        r_hs1, r_vs1, r_hsO, r_vsO;
    logic        r_hPolLow, r_vPolLow;
    logic [9:0]  r_hCnt, r_vCnt, r_x, r_y;
    logic [18:0] r_win, r_hHigh, r_vHigh;
    logic [7:0]  r_goodFrames;
    logic        r_de, r_locked;

    logic        w_hEdge, w_vEdge, w_hSat, w_badLine, w_badFrame, w_goodFrame;
    logic        w_winEnd, w_clrGood, w_incGood, w_de;
    logic [9:0]  w_hNext, w_vNext;
    logic [18:0] w_hHighTot, w_vHighTot;

    // Edges compare the live input against the previous sample under the same polarity,
    // so a polarity flip at window end never looks like an edge.
    assign w_hEdge     = (hsync ^ r_hPolLow) & ~(r_hs1 ^ r_hPolLow);
    assign w_vEdge     = (vsync ^ r_vPolLow) & ~(r_vs1 ^ r_vPolLow);
    assign w_hNext     = w_hEdge ? 10'd0 : ((r_hCnt == 10'h3FF) ? 10'h3FF : r_hCnt + 10'd1);
    assign w_vNext     = w_vEdge ? 10'd0 :
                         ((w_hEdge && r_vCnt != 10'h3FF) ? r_vCnt + 10'd1 : r_vCnt);
    assign w_hSat      = (w_hNext == 10'h3FF);
    assign w_badLine   = (w_hEdge && r_hCnt != H_LAST) || w_hSat;
    assign w_goodFrame = w_vEdge && (r_vCnt == V_LAST);
    assign w_badFrame  = w_vEdge && (r_vCnt != V_LAST);
    assign w_winEnd    = (r_state == POL) && (r_win == WIN_LAST);
    assign w_hHighTot  = r_hHigh + 19'(hsync);
    assign w_vHighTot  = r_vHigh + 19'(vsync);

    always_comb begin
        w_nextState = r_state;
        w_clrGood   = 1'b0;
        w_incGood   = 1'b0;
        case (r_state)
            POL: begin
                if (w_winEnd) w_nextState = SEARCH;
            end
            SEARCH: begin
                if (w_vEdge) begin
                    w_nextState = MEASURE;
                    w_clrGood   = 1'b1;
                end
            end
            MEASURE: begin
                if (w_badLine || w_badFrame) begin
                    w_nextState = SEARCH;
                end else if (w_goodFrame) begin
                    if (r_goodFrames == GOOD_LAST) w_nextState = LOCKED;
                    else                           w_incGood   = 1'b1;
                end
            end
            LOCKED: begin
                if (w_hSat)                        w_nextState = POL;
                else if (w_badLine || w_badFrame)  w_nextState = SEARCH;
            end
            default: w_nextState = POL;
        endcase
    end

    always_ff @(posedge clk_pixel) begin
        if (reset) r_state <= POL;
        else       r_state <= w_nextState;
    end

    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            r_rgb1       <= '0;
            r_hs1        <= 1'b0;
            r_vs1        <= 1'b0;
            r_hCnt       <= '0;
            r_vCnt       <= '0;
            r_win        <= '0;
            r_hHigh      <= '0;
            r_vHigh      <= '0;
            r_hPolLow    <= 1'b0;
            r_vPolLow    <= 1'b0;
            r_goodFrames <= '0;
        end else begin
            r_rgb1 <= rgb;
            r_hs1  <= hsync;
            r_vs1  <= vsync;
            r_hCnt <= w_hNext;
            r_vCnt <= w_vNext;
            if (r_state == POL && !w_winEnd) begin
                r_win   <= r_win + 19'd1;
                r_hHigh <= w_hHighTot;
                r_vHigh <= w_vHighTot;
            end else begin
                r_win   <= '0;
                r_hHigh <= '0;
                r_vHigh <= '0;
            end
            // A sync that is high for most of the window is an active-low pulse.
            if (w_winEnd) begin
                r_hPolLow <= (w_hHighTot > WIN_HALF);
                r_vPolLow <= (w_vHighTot > WIN_HALF);
            end
            if (w_clrGood)      r_goodFrames <= '0;
            else if (w_incGood) r_goodFrames <= r_goodFrames + 8'd1;
        end
    end

    assign w_de = (r_state == LOCKED) &&
                  (r_hCnt >= H_START) && (r_hCnt < H_END) &&
                  (r_vCnt >= V_START) && (r_vCnt < V_END);

    // Counters already describe the previous sample, so one more register stage lines
    // de/x/y/locked up with the two-stage rgb/sync pipeline.
    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            r_rgbO   <= '0;
            r_hsO    <= 1'b0;
            r_vsO    <= 1'b0;
            r_de     <= 1'b0;
            r_x      <= '0;
            r_y      <= '0;
            r_locked <= 1'b0;
        end else begin
            r_rgbO   <= r_rgb1;
            r_hsO    <= r_hs1;
            r_vsO    <= r_vs1;
            r_de     <= w_de;
            r_x      <= w_de ? (r_hCnt - H_START) : 10'd0;
            r_y      <= w_de ? (r_vCnt - V_START) : 10'd0;
            r_locked <= (r_state == LOCKED);
        end
    end

    assign rgb_o   = r_rgbO;
    assign hsync_o = r_hsO;
    assign vsync_o = r_vsO;
    assign de      = r_de;
    assign x       = r_x;
    assign y       = r_y;
    assign locked  = r_locked;
    assign state   = r_state;

endmodule

// File: tb/tb_vga_sync_recovery.sv
// Self-checking bench for vga_sync_recovery using a shrunken video timing so that
// polarity detection, locking, loss of lock and reset all fit in a short run.
module tb_vga_sync_recovery;

    localparam int HA = 16, HS = 4, HBP = 4, HT = 32;
    localparam int VA = 30, VS = 2, VBP = 3, VT = 40;
    localparam int LF = 2;
    localparam int W  = HT * VT;
    localparam int NEVER = 32'h3FFF_FFFF;

    logic       clk_pixel = 1'b0;
    logic       reset = 1'b1;
    logic       hsync = 1'b0;
    logic       vsync = 1'b0;
    logic [2:0] rgb = 3'd0;
    logic [2:0] rgb_o;
    logic       hsync_o, vsync_o, de, locked;
    logic [9:0] x, y;
    logic [1:0] state;

    always #5 clk_pixel = ~clk_pixel;

    vga_sync_recovery #(
        .H_ACTIVE(HA), .H_SYNC(HS), .H_BP(HBP), .H_TOTAL(HT),
        .V_ACTIVE(VA), .V_SYNC(VS), .V_BP(VBP), .V_TOTAL(VT),
        .LOCK_FRAMES(LF)
    ) dut (
        .clk_pixel(clk_pixel), .reset(reset), .hsync(hsync), .vsync(vsync), .rgb(rgb),
        .rgb_o(rgb_o), .hsync_o(hsync_o), .vsync_o(vsync_o), .de(de),
        .x(x), .y(y), .locked(locked), .state(state)
    );

    typedef struct {
        logic       rst;
        logic [2:0] rgb;
        logic       hs;
        logic       vs;
        logic [2:0] expRgb;
        logic       expHs;
        logic       expVs;
    } vec_t;

    typedef struct {
        int         n;
        bit         timed;
        logic [2:0] rgb;
        logic       hs, vs, lk, de;
        logic [9:0] x, y;
    } sample_t;

    vec_t    vecs[11];
    sample_t curExp, prevExp;
    bit      prevValid;

    int passCount = 0;
    int checkCount = 0;

    // Stream generator and scenario knobs
    int  curN, gHp, gLine, gLen;
    int  shortStart, holdFrom, lockA, lossB, lockC;
    bit  negSync, rampRgb;
    int  frmLo, frmHi, deCount;
    bit  sawFirst;
    logic [19:0] firstXY, lastXY;

    task automatic checkEq(input string name, input logic [31:0] act, input logic [31:0] exp);
        checkCount++;
        if (act === exp) passCount++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic checkOutput(input sample_t e);
        checkEq($sformatf("pipe@%0d", e.n), 32'({rgb_o, hsync_o, vsync_o}),
                32'({e.rgb, e.hs, e.vs}));
        if (e.timed)
            checkEq($sformatf("timing@%0d", e.n), 32'({locked, de, x, y}),
                    32'({e.lk, e.de, e.x, e.y}));
        if (e.n >= frmLo && e.n < frmHi && de === 1'b1) begin
            deCount++;
            if (!sawFirst) begin
                firstXY  = {x, y};
                sawFirst = 1'b1;
            end
            lastXY = {x, y};
        end
    endtask

    // Reference stream: position-based timing, expected lock from scenario intervals.
    task automatic nextSample();
        bit hsAct, vsAct, holding, act;
        if (gHp == 0) gLen = (curN == shortStart) ? HT - 1 : HT;
        holding = (holdFrom >= 0) && (curN >= holdFrom);
        hsAct   = (gHp < HS) && !holding;
        vsAct   = (gLine < VS);
        hsync   = negSync ? !hsAct : hsAct;
        vsync   = negSync ? !vsAct : vsAct;
        rgb     = rampRgb ? 3'(curN) : 3'($urandom);
        act     = (gHp >= HS + HBP) && (gHp < HS + HBP + HA) &&
                  (gLine >= VS + VBP) && (gLine < VS + VBP + VA);
        curExp.n     = curN;
        curExp.timed = !holding;
        curExp.rgb   = rgb;
        curExp.hs    = hsync;
        curExp.vs    = vsync;
        curExp.lk    = ((curN >= lockA) && (curN < lossB)) || (curN >= lockC);
        curExp.de    = curExp.lk && act;
        curExp.x     = curExp.de ? 10'(gHp - HS - HBP) : 10'd0;
        curExp.y     = curExp.de ? 10'(gLine - VS - VBP) : 10'd0;
        gHp++;
        if (gHp == gLen) begin
            gHp   = 0;
            gLine = (gLine == VT - 1) ? 0 : gLine + 1;
        end
    endtask

    task automatic runStream(input int nSamples);
        for (int k = 0; k < nSamples; k++) begin
            nextSample();
            @(posedge clk_pixel);
            #1;
            if (prevValid) checkOutput(prevExp);
            prevExp   = curExp;
            prevValid = 1'b1;
            curN++;
        end
    endtask

    task automatic applyReset(input int cycles);
        reset = 1'b1;
        hsync = negSync;
        vsync = negSync;
        rgb   = 3'd0;
        repeat (cycles) @(posedge clk_pixel);
        #1;
        checkEq("resetOutputs", 32'({state, locked, de, x, y, rgb_o, hsync_o, vsync_o}), 32'd0);
        reset     = 1'b0;
        curN      = 0;
        gHp       = 0;
        gLine     = 0;
        gLen      = HT;
        prevValid = 1'b0;
    endtask

    task automatic startFrameCount(input int lo);
        frmLo    = lo;
        frmHi    = lo + W;
        deCount  = 0;
        sawFirst = 1'b0;
        firstXY  = '1;
        lastXY   = '1;
    endtask

    task automatic checkFrameCount(input string tag);
        checkEq({tag, "DeCount"}, 32'(deCount), 32'(HA * VA));
        checkEq({tag, "FirstXY"}, 32'(firstXY), 32'({10'd0, 10'd0}));
        checkEq({tag, "LastXY"},  32'(lastXY),  32'({10'(HA - 1), 10'(VA - 1)}));
    endtask

    task automatic applyStimulus();
        for (int i = 0; i < 11; i++) begin
            reset = vecs[i].rst;
            rgb   = vecs[i].rgb;
            hsync = vecs[i].hs;
            vsync = vecs[i].vs;
            @(posedge clk_pixel);
            #1;
            checkEq($sformatf("vec%0d", i),
                    32'({rgb_o, hsync_o, vsync_o, state, de, locked}),
                    32'({vecs[i].expRgb, vecs[i].expHs, vecs[i].expVs, 2'b00, 1'b0, 1'b0}));
        end
    endtask

    initial begin
        // {rst, rgb, hs, vs} -> outputs reflect the previous record once two reset-free edges pass
        vecs[0]  = '{1'b1, 3'd5, 1'b1, 1'b1, 3'd0, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 3'd6, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 3'd1, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 3'd2, 1'b0, 1'b1, 3'd1, 1'b1, 1'b0};
        vecs[4]  = '{1'b0, 3'd7, 1'b1, 1'b1, 3'd2, 1'b0, 1'b1};
        vecs[5]  = '{1'b1, 3'd4, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 3'd3, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 3'd6, 1'b0, 1'b1, 3'd3, 1'b1, 1'b0};
        vecs[8]  = '{1'b0, 3'd0, 1'b0, 1'b0, 3'd6, 1'b0, 1'b1};
        vecs[9]  = '{1'b0, 3'd5, 1'b1, 1'b1, 3'd0, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 3'd2, 1'b0, 1'b0, 3'd5, 1'b1, 1'b1};

        frmLo = NEVER; frmHi = NEVER; deCount = 0; sawFirst = 1'b0;
        prevValid = 1'b0; holdFrom = -1; shortStart = -1;
        applyStimulus();

        // Negative sync, random pixels: lock, then one line shortened by a clock, then relock
        negSync    = 1'b1;
        rampRgb    = 1'b0;
        holdFrom   = -1;
        shortStart = 4 * W + 10 * HT;
        lockA      = 3 * W;
        lossB      = shortStart + HT - 1;
        lockC      = (5 * W - 1) + 2 * W;
        startFrameCount(3 * W);
        applyReset(3);
        runStream(7 * W + W / 2);
        checkFrameCount("neg");
        checkEq("negRelockState", 32'(state), 32'd3);

        // Positive sync with an rgb ramp, then a one-cycle reset mid-lock and a fresh lock
        negSync    = 1'b0;
        rampRgb    = 1'b1;
        shortStart = -1;
        lockA      = 3 * W;
        lossB      = NEVER;
        lockC      = NEVER;
        startFrameCount(3 * W);
        applyReset(2);
        runStream(5 * W);
        checkFrameCount("pos");
        checkEq("posLockedState", 32'({state, locked}), 32'({2'd3, 1'b1}));
        startFrameCount(NEVER);
        applyReset(1);
        runStream(3 * W + 20);
        checkEq("postPulseRelock", 32'({state, locked}), 32'({2'd3, 1'b1}));

        // hsync stuck while locked: h_cnt runs to saturation and the tracker restarts polarity
        negSync  = 1'b1;
        rampRgb  = 1'b0;
        holdFrom = 3 * W + HT + 1;
        lockA    = 3 * W;
        lossB    = NEVER;
        lockC    = NEVER;
        applyReset(2);
        runStream(holdFrom + 900);
        checkEq("holdBeforeSat", 32'({state, locked}), 32'({2'd3, 1'b1}));
        runStream(200);
        checkEq("holdAfterSat", 32'({state, locked, de}), 32'({2'd0, 1'b0, 1'b0}));

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
